// File: rtl/control_motor_persiana.sv
// control_motor_persiana: blind motor controller FSM with dead-time pause, limit sensing and optional run timeout (PERSIANA_TIMEOUT_EN)
module control_motor_persiana #(
  parameter int unsigned T_MAX  = 40,
  parameter int unsigned DEAD_T = 2
) (
  input  logic       Reloj,
  input  logic       reset,
  input  logic       subir,
  input  logic       bajar,
  input  logic       Ssup,
  input  logic       Sinf,
  input  logic       fallo_clr,
  output logic       mot_arriba,
  output logic       mot_abajo,
  output logic       fallo,
  output logic [2:0] estado
);
  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    SUBIENDO = 3'd1,
    BAJANDO  = 3'd2,
    PAUSA    = 3'd3,
    FALLO    = 3'd4
  } state_t;
  state_t state_q, state_d;
  logic [7:0] pausa_q, pausa_d;
  logic timeout;
  logic contra, stop_up, stop_dn, pausa_fin;
  assign contra    = Ssup & Sinf;
  assign stop_up   = Ssup | ~subir | bajar;
  assign stop_dn   = Sinf | ~bajar | subir;
  assign pausa_fin = pausa_q == 8'(DEAD_T - 1);
`ifdef PERSIANA_TIMEOUT_EN
  logic [7:0] run_q, run_d;
  logic moving_q, moving_d;
  assign moving_q = state_q == SUBIENDO || state_q == BAJANDO;
  assign moving_d = state_d == SUBIENDO || state_d == BAJANDO;
  assign timeout  = run_q == 8'(T_MAX - 1);
  // run counter: zero outside a movement, saturating count while the motor is driven
  always_comb begin
    run_d = (moving_q && moving_d) ? ((run_q == 8'hFF) ? run_q : run_q + 8'd1) : 8'd0;
  end
  // run counter register
  always_ff @(posedge Reloj or posedge reset) begin
    if (reset) run_q <= 8'd0;
    else       run_q <= run_d;
  end
`else
  assign timeout = 1'b0;
`endif
  // next state: contradiction beats stop, stop beats timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      REPOSO:   state_d = contra                   ? FALLO    :
                          (subir & ~bajar & ~Ssup) ? SUBIENDO :
                          (bajar & ~subir & ~Sinf) ? BAJANDO  : REPOSO;
      SUBIENDO: state_d = contra ? FALLO : stop_up ? PAUSA : timeout ? FALLO : SUBIENDO;
      BAJANDO:  state_d = contra ? FALLO : stop_dn ? PAUSA : timeout ? FALLO : BAJANDO;
      PAUSA:    state_d = pausa_fin ? REPOSO : PAUSA;
      FALLO:    state_d = (fallo_clr & ~subir & ~bajar) ? REPOSO : FALLO;
      default:  state_d = REPOSO;
    endcase
  end
  // dead-time counter: zero on entry to PAUSA, saturating count while in it
  always_comb begin
    pausa_d = (state_q == PAUSA && state_d == PAUSA) ? ((pausa_q == 8'hFF) ? pausa_q : pausa_q + 8'd1) : 8'd0;
  end
  // state and dead-time registers
  always_ff @(posedge Reloj or posedge reset) begin
    if (reset) begin
      state_q <= REPOSO;
      pausa_q <= 8'd0;
    end else begin
      state_q <= state_d;
      pausa_q <= pausa_d;
    end
  end
  assign mot_arriba = state_q == SUBIENDO;
  assign mot_abajo  = state_q == BAJANDO;
  assign fallo      = state_q == FALLO;
  assign estado     = state_q;
endmodule

// File: tb/tb_control_motor_persiana.sv
// tb_control_motor_persiana: directed self-checking bench for control_motor_persiana
module tb_control_motor_persiana;
  logic Reloj = 1'b0;
  logic reset, subir, bajar, Ssup, Sinf, fallo_clr;
  logic mot_arriba, mot_abajo, fallo;
  logic [2:0] estado;
  int checks = 0;
  int failures = 0;
  int overlap = 0;
  int run = 0;

  control_motor_persiana dut (
    .Reloj(Reloj), .reset(reset), .subir(subir), .bajar(bajar), .Ssup(Ssup), .Sinf(Sinf),
    .fallo_clr(fallo_clr), .mot_arriba(mot_arriba), .mot_abajo(mot_abajo), .fallo(fallo), .estado(estado)
  );

  always #5 Reloj = ~Reloj;

  always @(negedge Reloj) if (mot_arriba && mot_abajo) overlap++;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int st, input logic up, input logic dn, input logic fl);
    chk({tag, ".estado"}, int'(estado), st);
    chk({tag, ".arriba"}, int'(mot_arriba), int'(up));
    chk({tag, ".abajo"}, int'(mot_abajo), int'(dn));
    chk({tag, ".fallo"}, int'(fallo), int'(fl));
  endtask

  task automatic step();
    @(posedge Reloj);
    #1;
  endtask

  initial begin
    reset = 1'b1; subir = 0; bajar = 0; Ssup = 0; Sinf = 0; fallo_clr = 0;
    #12;
    chk_out("reset", 0, 0, 0, 0);
    reset = 1'b0;
    // raise for 10 cycles, stop at upper limit
    subir = 1;
    step();
    chk_out("up_entry", 1, 1, 0, 0);
    run = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (mot_arriba) run++;
    end
    chk("up_run_cycles", run, 10);
    Ssup = 1;
    step();
    chk_out("up_pausa1", 3, 0, 0, 0);
    step();
    chk_out("up_pausa2", 3, 0, 0, 0);
    step();
    chk_out("up_reposo", 0, 0, 0, 0);
    step();
    chk_out("up_at_limit", 0, 0, 0, 0);
    subir = 0; Ssup = 0;
    // long lowering: timeout or no timeout depending on build
    bajar = 1;
    step();
    chk_out("dn_entry", 2, 0, 1, 0);
    run = 1;
`ifdef PERSIANA_TIMEOUT_EN
    for (int i = 0; i < 39; i++) begin
      step();
      if (mot_abajo) run++;
    end
    chk("dn_run_cycles", run, 40);
    step();
    chk_out("timeout", 4, 0, 0, 1);
    fallo_clr = 1;
    step();
    chk_out("clr_with_bajar", 4, 0, 0, 1);
    bajar = 0;
    step();
    chk_out("clr_ok", 0, 0, 0, 0);
    fallo_clr = 0;
`else
    for (int i = 0; i < 299; i++) begin
      step();
      if (mot_abajo) run++;
    end
    chk("dn_no_timeout", run, 300);
    chk_out("dn_still", 2, 0, 1, 0);
    bajar = 0;
    step();
    chk_out("dn_stop", 3, 0, 0, 0);
    step();
    step();
    chk_out("dn_reposo", 0, 0, 0, 0);
`endif
    // reversal up -> down
    subir = 1;
    step();
    step();
    chk_out("rev_up", 1, 1, 0, 0);
    subir = 0; bajar = 1;
    step();
    chk_out("rev_pausa1", 3, 0, 0, 0);
    step();
    chk_out("rev_pausa2", 3, 0, 0, 0);
    step();
    chk_out("rev_reposo", 0, 0, 0, 0);
    step();
    chk_out("rev_down", 2, 0, 1, 0);
    // sensor contradiction while lowering
    Ssup = 1; Sinf = 1;
    step();
    chk_out("contra_dn", 4, 0, 0, 1);
    Ssup = 0; Sinf = 0; bajar = 0; fallo_clr = 1;
    step();
    chk_out("contra_clr", 0, 0, 0, 0);
    fallo_clr = 0;
    // both requests in REPOSO
    subir = 1; bajar = 1;
    step();
    chk_out("both_req", 0, 0, 0, 0);
    subir = 0;
    Sinf = 1;
    step();
    chk_out("dn_at_limit", 0, 0, 0, 0);
    bajar = 0; Ssup = 1;
    step();
    chk_out("contra_reposo", 4, 0, 0, 1);
    Ssup = 0; Sinf = 0; fallo_clr = 1;
    step();
    chk_out("contra_reposo_clr", 0, 0, 0, 0);
    fallo_clr = 0;
    // asynchronous reset mid-movement
    bajar = 1;
    step();
    chk_out("pre_reset", 2, 0, 1, 0);
    #2;
    reset = 1;
    #1;
    chk_out("async_reset", 0, 0, 0, 0);
    reset = 0; bajar = 0;
    step();
    chk_out("post_reset", 0, 0, 0, 0);
    chk("never_both", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
